// File: rtl/io_pkg.sv
// Shared I/O-controller definitions: device IDs, timer register offsets,
// CTRL/STATUS bit positions and the channel state type.
package io_pkg;

    localparam logic [10:0] TIMER_DEVICE = 11'h7FA;

    localparam logic [3:0] OFF_CTRL0     = 4'h0;
    localparam logic [3:0] OFF_RELOAD0   = 4'h1;
    localparam logic [3:0] OFF_COUNT0    = 4'h2;
    localparam logic [3:0] OFF_STATUS    = 4'h3;
    localparam logic [3:0] OFF_CTRL1     = 4'h4;
    localparam logic [3:0] OFF_RELOAD1   = 4'h5;
    localparam logic [3:0] OFF_COUNT1    = 4'h6;
    localparam logic [3:0] OFF_STATUS_RO = 4'h7;
    localparam logic [3:0] OFF_CYC_LO    = 4'h8;
    localparam logic [3:0] OFF_CYC_HI    = 4'h9;
    localparam logic [3:0] OFF_ID        = 4'hF;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_AUTO   = 1;
    localparam int CTRL_IE     = 2;
    localparam int CTRL_PS_LSB = 4;

    localparam int ST_EXP0 = 0;
    localparam int ST_OVF0 = 1;
    localparam int ST_EXP1 = 2;
    localparam int ST_OVF1 = 3;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_t;

    // Terminal prescaler value for a tick every 2^ps cycles.
    function automatic logic [14:0] presc_limit(input logic [3:0] ps);
        return 15'((32'd1 << ps) - 32'd1);
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: CTRL/RELOAD/COUNT registers, prescaler and
// IDLE/RUN state; flags one-cycle exp_pulse when the count expires.
module timer_channel
    import io_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ctrl_wr,
    input  logic        reload_wr,
    input  logic        count_wr,
    input  logic [15:0] wdata,
    output logic [15:0] ctrl,
    output logic [15:0] reload,
    output logic [15:0] count,
    output logic        exp_pulse
);

    ch_state_t   state;
    logic        auto_rl;
    logic        ie;
    logic [3:0]  ps;
    logic [14:0] presc;
    logic        tick;

    assign tick      = (state == CH_RUN) && (presc == presc_limit(ps));
    // A direct COUNT write on a tick cycle suppresses both decrement and expiry.
    assign exp_pulse = tick && !count_wr && (count == 16'h0000);
    assign ctrl      = {8'h00, ps, 1'b0, ie, auto_rl, (state == CH_RUN)};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= CH_IDLE;
            auto_rl <= 1'b0;
            ie      <= 1'b0;
            ps      <= 4'h0;
            presc   <= 15'h0000;
            reload  <= 16'h0000;
            count   <= 16'h0000;
        end else begin
            if (ctrl_wr) begin
                state   <= wdata[CTRL_EN] ? CH_RUN : CH_IDLE;
                auto_rl <= wdata[CTRL_AUTO];
                ie      <= wdata[CTRL_IE];
                ps      <= wdata[CTRL_PS_LSB +: 4];
                presc   <= 15'h0000;
            end else begin
                if (tick)
                    presc <= 15'h0000;
                else if (state == CH_RUN)
                    presc <= presc + 15'd1;
                if (exp_pulse && !auto_rl)
                    state <= CH_IDLE;
            end

            if (reload_wr)
                reload <= wdata;

            if (count_wr)
                count <= wdata;
            else if (tick) begin
                if (count != 16'h0000)
                    count <= count - 16'd1;
                else if (auto_rl)
                    count <= reload;
            end
        end
    end

endmodule

// File: rtl/timer_device.sv
// Timer peripheral top: register decode, sticky W1C status flags, irq,
// 32-bit cycle counter with high-half shadow, and combinational readback.
module timer_device
    import io_pkg::*;
#(
    parameter logic [15:0] ID_VALUE     = 16'h7132,
    parameter bit          CYCLE_CNT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        device_select,
    input  logic [3:0]  register_offset,
    input  logic        read_req,
    input  logic        write_req,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        irq
);

    logic        rd, wr;
    logic [15:0] ctrl0, reload0, count0, ctrl1, reload1, count1;
    logic        exp0, exp1;
    logic [3:0]  status, hw_set, sw_clr;
    logic [31:0] cycle;
    logic [15:0] shadow;

    assign rd = device_select & read_req;
    assign wr = device_select & write_req;

    timer_channel u_ch0 (
        .clk       (clk),
        .reset_n   (reset_n),
        .ctrl_wr   (wr && register_offset == OFF_CTRL0),
        .reload_wr (wr && register_offset == OFF_RELOAD0),
        .count_wr  (wr && register_offset == OFF_COUNT0),
        .wdata     (wdata),
        .ctrl      (ctrl0),
        .reload    (reload0),
        .count     (count0),
        .exp_pulse (exp0)
    );

    timer_channel u_ch1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .ctrl_wr   (wr && register_offset == OFF_CTRL1),
        .reload_wr (wr && register_offset == OFF_RELOAD1),
        .count_wr  (wr && register_offset == OFF_COUNT1),
        .wdata     (wdata),
        .ctrl      (ctrl1),
        .reload    (reload1),
        .count     (count1),
        .exp_pulse (exp1)
    );

    // Overflow is a second expiry while the expiry flag is still pending.
    assign hw_set = {exp1 & status[ST_EXP1], exp1, exp0 & status[ST_EXP0], exp0};
    assign sw_clr = (wr && register_offset == OFF_STATUS) ? wdata[3:0] : 4'h0;
    assign irq    = (status[ST_EXP0] & ctrl0[CTRL_IE]) | (status[ST_EXP1] & ctrl1[CTRL_IE]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            status <= 4'h0;
        else
            status <= hw_set | (status & ~sw_clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle  <= 32'h0000_0000;
            shadow <= 16'h0000;
        end else if (CYCLE_CNT_EN) begin
            if (wr && register_offset == OFF_CYC_LO)
                cycle <= 32'h0000_0000;
            else
                cycle <= cycle + 32'd1;
            if (rd && register_offset == OFF_CYC_LO)
                shadow <= cycle[31:16];
        end
    end

    always_comb begin
        rdata = 16'h0000;
        if (rd) begin
            case (register_offset)
                OFF_CTRL0:     rdata = ctrl0;
                OFF_RELOAD0:   rdata = reload0;
                OFF_COUNT0:    rdata = count0;
                OFF_STATUS:    rdata = {12'h000, status};
                OFF_CTRL1:     rdata = ctrl1;
                OFF_RELOAD1:   rdata = reload1;
                OFF_COUNT1:    rdata = count1;
                OFF_STATUS_RO: rdata = {12'h000, status};
                OFF_CYC_LO:    rdata = cycle[15:0];
                OFF_CYC_HI:    rdata = shadow;
                OFF_ID:        rdata = ID_VALUE;
                default:       rdata = 16'h0000;
            endcase
        end
    end

endmodule

// File: doc/timer_device.md
Name: timer_device

Overview:
- Memory-mapped timer peripheral: two programmable countdown channels, sticky expiry flags, an interrupt output and a 32-bit free-running cycle counter.
- Responder on the I/O controller's device bus as Device 2042, addresses 0xFFA0-0xFFAF.
- Takes the standard per-device signals: select, offset, request strobes, wdata, rdata.
- Plugs into the I/O controller read mux alongside the UART, GPU and audio devices.

Parameters:
- ID_VALUE, 16'h7132, constant returned at offset 0xF.
- CYCLE_CNT_EN, 1, 1 = free-running counter present; 0 = offsets 0x8/0x9 read 0 and writes are ignored.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset. One clock; no other reset.
- device_select  in  1  this device addressed (registered by the I/O controller).
- register_offset  in  4  register index.
- read_req  in  1  read strobe, one cycle.
- write_req  in  1  write strobe, one cycle.
- wdata  in  16  write data.
- rdata  out  16  read data, combinational.
- irq  out  1  level interrupt.

Behaviour:
- Access qualifiers: rd = device_select & read_req; wr = device_select & write_req.
- Writes and read side effects commit on the rising clk edge of the strobe cycle.
- rdata is combinational from register_offset and current state, valid in the same cycle as rd (0-cycle latency). It is 16'h0000 when rd is low.
- Register map, channel n (n=0 at 0x0-0x2, n=1 at 0x4-0x6):
  - CTRLn: bit0 EN, bit1 AUTO (auto-reload), bit2 IE (interrupt enable), bits[7:4] PS (tick = clk/2^PS). Other bits write-ignored, read 0.
  - RELOADn: 16-bit reload value.
  - COUNTn: reads the live count; a write loads the count directly.
- Other registers:
  - 0x3 STATUS (write-1-to-clear): bit0 EXP0, bit1 OVF0, bit2 EXP1, bit3 OVF1.
  - 0x7: mirror of STATUS, read-only.
  - 0x8 CYC_LO: read returns cycle[15:0] and latches cycle[31:16] into a shadow register. A write of any data clears the 32-bit counter.
  - 0x9 CYC_HI: reads the shadow register.
  - 0xF: ID_VALUE.
  - Unmapped offsets: read 0, writes ignored.
- Prescaler (per channel, 15-bit):
  - Counts only while EN=1.
  - tick = EN & (presc == 2^PS - 1), after which presc wraps to 0.
  - PS=0 gives a tick every cycle.
  - Any CTRLn write clears presc to 0.
- Count on tick:
  - count != 0: count <= count - 1.
  - count == 0 (expiry): set EXPn; if EXPn was already 1, also set OVFn. Then:
    - AUTO=1: count <= RELOADn.
    - AUTO=0: EN <= 0 (one-shot); count stays 0.
  - Resulting period with AUTO=1 is (RELOAD+1) × 2^PS cycles.
- Channel FSM (per channel): IDLE (EN=0) and RUN (EN=1).
  - IDLE -> RUN: CTRL write with EN=1.
  - RUN -> IDLE: CTRL write with EN=0, or a one-shot expiry.
  - Count and flags are unchanged on any transition.
- Priorities:
  - COUNTn write in the same cycle as a tick: the write wins, no decrement, no expiry.
  - CTRLn write in the same cycle as a one-shot expiry: the written EN wins.
  - Hardware set of EXP/OVF in the same cycle as a W1C of that bit: the set wins.
- irq = (EXP0 & IE0) | (EXP1 & IE1). It is a pure OR of flops, visible the cycle after expiry.
- Cycle counter:
  - Increments every clk and wraps 0xFFFFFFFF -> 0.
  - A clear write takes priority over the increment.
  - CYC_LO returns the pre-edge value.
- Reset (async, any time including mid-count): all CTRL/RELOAD/COUNT, flags, prescalers, cycle counter and shadow go to 0, so irq=0. Both channels are in IDLE.
- Software contract: a read issued the cycle after a write to the same register may return stale data; software inserts one NOP between them.

Decomposition:
- Shared package (io_pkg): device ID localparams (add TIMER_DEVICE = 11'h7FA beside the existing IDs), timer register offsets, CTRL bit positions, STATUS bit positions.
- Sub-module timer_channel, instantiated twice. It owns CTRL/RELOAD/COUNT, the prescaler and the channel FSM, and outputs exp_pulse and its registers for readback.
- STATUS flags, irq and the cycle counter live in timer_device.

Test Plan:
- Reset: assert reset_n low mid-run with COUNT0=0x0005 -> every register reads 0x0000, irq=0, offset 0xF reads 0x7132.
- Auto-reload: RELOAD0=3, CTRL0=0x0007 (EN, AUTO, IE, PS=0) -> EXP0 and irq rise every 4 cycles; second expiry without a clear -> STATUS=0x0003.
- One-shot with prescaler: COUNT1=2, CTRL1=0x0021 (PS=2) -> expiry after 12 cycles, CTRL1 reads 0x0020, COUNT1 holds 0.
- W1C race: write STATUS=0x0001 in the exact expiry cycle -> EXP0 remains 1; a later write of 0x0001 clears it and irq drops the next cycle.
- COUNT write vs tick: write COUNT0=0x0100 on a tick cycle -> reads 0x0100, no decrement that cycle.
- Cycle counter: clear via write to 0x8, wait 0x1_0003 cycles, read 0x8 then 0x9 -> 0x0003 then 0x0001, with the shadow stable while cycles continue.
